// File: rtl/vadd_adder_arbiter.sv
// Packet-locked round-robin arbiter sharing one vadd adder between NUM_REQ AXI-Stream
// requesters; a tag FIFO of grant ids steers adder results back to their owner.
module vadd_adder_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned S_DATA_WIDTH = 64,
    parameter int unsigned M_DATA_WIDTH = 32,
    parameter int unsigned TAG_DEPTH    = 8
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_REQ-1:0]                req_tvalid,
    output logic [NUM_REQ-1:0]                req_tready,
    input  logic [NUM_REQ*S_DATA_WIDTH-1:0]   req_tdata,
    input  logic [NUM_REQ-1:0]                req_tlast,
    output logic                              add_s_tvalid,
    input  logic                              add_s_tready,
    output logic [S_DATA_WIDTH-1:0]           add_s_tdata,
    output logic                              add_s_tlast,
    input  logic                              add_m_tvalid,
    output logic                              add_m_tready,
    input  logic [M_DATA_WIDTH-1:0]           add_m_tdata,
    input  logic                              add_m_tlast,
    output logic [NUM_REQ-1:0]                rsp_tvalid,
    input  logic [NUM_REQ-1:0]                rsp_tready,
    output logic [M_DATA_WIDTH-1:0]           rsp_tdata,
    output logic                              rsp_tlast,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              tag_err
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

    typedef enum logic [0:0] {StArb, StStream} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        rr_q, rr_d;
    logic [IdW-1:0]        grant_q, grant_d;
    logic [IdW-1:0]        tags_q [TAG_DEPTH];
    logic [IdW-1:0]        tags_d [TAG_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  tag_err_q, tag_err_d;
    logic                  busy_q, busy_d;

    logic [2*NUM_REQ-1:0]  vld_dbl;
    logic [NUM_REQ-1:0]    vld_rot;
    logic [IdW-1:0]        win_off, win_id;
    logic [IdW:0]          win_sum;
    logic                  win_found;

    logic                  g_tvalid, g_tlast;
    logic [S_DATA_WIDTH-1:0] g_tdata;

    logic [IdW-1:0]        tag_head;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop, s_last_fire;

    // Rotate valids so the rr pointer sits at bit 0; lowest set bit is the winner.
    always_comb begin
        vld_dbl   = {req_tvalid, req_tvalid};
        vld_rot   = NUM_REQ'(vld_dbl >> rr_q);
        win_found = 1'b0;
        win_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (vld_rot[k]) begin
                win_found = 1'b1;
                win_off   = IdW'(k);
            end
        end
        win_sum = {1'b0, rr_q} + {1'b0, win_off};
        if (win_sum >= (IdW+1)'(NUM_REQ)) begin
            win_sum = win_sum - (IdW+1)'(NUM_REQ);
        end
        win_id = win_sum[IdW-1:0];
    end

    always_comb begin
        g_tvalid = 1'b0;
        g_tlast  = 1'b0;
        g_tdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IdW'(i)) begin
                g_tvalid = req_tvalid[i];
                g_tlast  = req_tlast[i];
                g_tdata  = req_tdata[i*S_DATA_WIDTH +: S_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        tag_head   = tags_q[rd_ptr_q];
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CntW'(TAG_DEPTH));

        add_s_tvalid = (state_q == StStream) & g_tvalid;
        add_s_tdata  = g_tdata;
        add_s_tlast  = g_tlast;
        req_tready   = '0;
        if (state_q == StStream) begin
            req_tready[grant_q] = add_s_tready;
        end
        s_last_fire = (state_q == StStream) & g_tvalid & add_s_tready & g_tlast;

        rsp_tvalid   = '0;
        add_m_tready = 1'b0;
        if (!fifo_empty) begin
            rsp_tvalid[tag_head] = add_m_tvalid;
            add_m_tready         = rsp_tready[tag_head];
        end
        rsp_tdata = add_m_tdata;
        rsp_tlast = add_m_tlast;

        pop  = add_m_tvalid & add_m_tready & add_m_tlast;
        push = (state_q == StArb) & win_found & ~fifo_full;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        tags_d    = tags_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        tag_err_d = tag_err_q | (fifo_empty & add_m_tvalid);

        unique case (state_q)
            StArb: begin
                if (push) begin
                    grant_d = win_id;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (s_last_fire) begin
                    rr_d    = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase

        if (push) begin
            tags_d[wr_ptr_q] = win_id;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end

        busy_d = (state_d == StStream) | (cnt_d != '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StArb;
            rr_q      <= '0;
            grant_q   <= '0;
            tags_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tag_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            tags_q    <= tags_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tag_err_q <= tag_err_d;
            busy_q    <= busy_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_vadd_adder_arbiter.sv
// Self-checking bench for vadd_adder_arbiter: bench-driven requester sources and a
// scoreboard of expected adder beats and result tags.
module tb_vadd_adder_arbiter;

    localparam int N  = 4;
    localparam int SW = 64;
    localparam int MW = 32;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic            aresetn;
    logic [N-1:0]    req_tvalid, req_tready, req_tlast;
    logic [N*SW-1:0] req_tdata;
    logic            add_s_tvalid, add_s_tready, add_s_tlast;
    logic [SW-1:0]   add_s_tdata;
    logic            add_m_tvalid, add_m_tready, add_m_tlast;
    logic [MW-1:0]   add_m_tdata;
    logic [N-1:0]    rsp_tvalid, rsp_tready;
    logic [MW-1:0]   rsp_tdata;
    logic            rsp_tlast;
    logic [1:0]      grant_id;
    logic            busy, tag_err;

    vadd_adder_arbiter #(
        .NUM_REQ(N), .S_DATA_WIDTH(SW), .M_DATA_WIDTH(MW), .TAG_DEPTH(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
        .req_tlast(req_tlast),
        .add_s_tvalid(add_s_tvalid), .add_s_tready(add_s_tready), .add_s_tdata(add_s_tdata),
        .add_s_tlast(add_s_tlast),
        .add_m_tvalid(add_m_tvalid), .add_m_tready(add_m_tready), .add_m_tdata(add_m_tdata),
        .add_m_tlast(add_m_tlast),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
        .rsp_tlast(rsp_tlast),
        .grant_id(grant_id), .busy(busy), .tag_err(tag_err)
    );

    typedef struct {
        logic [SW-1:0] data;
        logic          last;
        int            id;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_tags[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fire_cnt, first_fire, last_fire;
    bit lock_chk = 1'b0;

    int src_pkts[N];
    int src_len[N];
    int src_beat[N];
    int src_pktno[N];

    function automatic logic [SW-1:0] mk_data(int i, int p, int b);
        return {32'(i), 16'(p), 16'(b)};
    endfunction

    task automatic exp_pkt(int i, int p, int len);
        beat_t e;
        for (int b = 0; b < len; b++) begin
            e.data = mk_data(i, p, b);
            e.last = (b == len - 1);
            e.id   = i;
            exp_beats.push_back(e);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            req_tvalid[i]          = (src_pkts[i] > 0);
            req_tdata[i*SW +: SW]  = mk_data(i, src_pktno[i], src_beat[i]);
            req_tlast[i]           = (src_beat[i] == src_len[i] - 1);
        end
    endtask

    task automatic add_packets(int i, int n, int len);
        src_pkts[i] += n;
        src_len[i]   = len;
        drive_sources();
    endtask

    // One clock: sample/score at negedge, advance sources just after posedge.
    task automatic step();
        logic [N-1:0] s_fire;
        logic [N-1:0] want_oh;
        beat_t        e;
        @(negedge aclk);
        cyc++;
        if (add_s_tvalid && add_s_tready) begin
            total++;
            if (exp_beats.size() == 0) begin
                bad++;
                $display("FAIL add_s_unexpected: got data=%h, want no beat", add_s_tdata);
            end else begin
                e = exp_beats.pop_front();
                if (add_s_tdata !== e.data || add_s_tlast !== e.last) begin
                    bad++;
                    $display("FAIL add_s_beat: got data=%h last=%b, want data=%h last=%b",
                             add_s_tdata, add_s_tlast, e.data, e.last);
                end
                if (e.last) exp_tags.push_back(e.id);
            end
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            fire_cnt++;
        end
        if (add_m_tvalid && add_m_tready) begin
            total++;
            if (exp_tags.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got rsp_tvalid=%b, want no handshake", rsp_tvalid);
            end else begin
                want_oh = '0;
                want_oh[exp_tags[0]] = 1'b1;
                if (rsp_tvalid !== want_oh) begin
                    bad++;
                    $display("FAIL rsp_route: got rsp_tvalid=%b, want %b", rsp_tvalid, want_oh);
                end
                if (add_m_tlast) void'(exp_tags.pop_front());
            end
        end
        if (lock_chk && src_pkts[2] > 0) begin
            total++;
            if (req_tready[0] !== 1'b0) begin
                bad++;
                $display("FAIL lock_req0_tready: got %b, want 0", req_tready[0]);
            end
        end
        s_fire = req_tvalid & req_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_fire[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_pktno[i]++;
                    src_pkts[i]--;
                end else begin
                    src_beat[i]++;
                end
            end
        end
        drive_sources();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_pkts[i] = 0; src_len[i] = 1; src_beat[i] = 0; src_pktno[i] = 0;
        end
        exp_beats.delete();
        exp_tags.delete();
        fire_cnt = 0; first_fire = -1; last_fire = -1;
        lock_chk = 1'b0;
        drive_sources();
        add_s_tready = 1'b1;
        add_m_tvalid = 1'b0;
        add_m_tdata  = '0;
        add_m_tlast  = 1'b0;
        rsp_tready   = '0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (req_tready !== 4'b0)   begin bad++; $display("FAIL reset_req_tready: got %b want 0000", req_tready); end
        total++;
        if (add_s_tvalid !== 1'b0) begin bad++; $display("FAIL reset_add_s_tvalid: got %b want 0", add_s_tvalid); end
        total++;
        if (add_m_tready !== 1'b0) begin bad++; $display("FAIL reset_add_m_tready: got %b want 0", add_m_tready); end
        total++;
        if (rsp_tvalid !== 4'b0)   begin bad++; $display("FAIL reset_rsp_tvalid: got %b want 0000", rsp_tvalid); end
        total++;
        if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (grant_id !== 2'd0)     begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        total++;
        if (tag_err !== 1'b0)      begin bad++; $display("FAIL reset_tag_err: got %b want 0", tag_err); end
        total++;
    endtask

    task automatic test_round_robin();
        do_reset();
        add_packets(0, 2, 2);
        add_packets(1, 1, 2);
        add_packets(2, 1, 2);
        add_packets(3, 1, 2);
        exp_pkt(0, 0, 2); exp_pkt(1, 0, 2); exp_pkt(2, 0, 2); exp_pkt(3, 0, 2); exp_pkt(0, 1, 2);
        for (int k = 0; k < 60 && exp_beats.size() > 0; k++) step();
        total++;
        if (exp_beats.size() != 0) begin
            bad++;
            $display("FAIL rr_timeout: got %0d beats left, want 0", exp_beats.size());
        end
        total++;
        if (fire_cnt != 10) begin
            bad++;
            $display("FAIL rr_beat_count: got %0d, want 10", fire_cnt);
        end
        // 5 packets x 2 beats plus one bubble between each pair of packets.
        total++;
        if (last_fire - first_fire != 13) begin
            bad++;
            $display("FAIL rr_bubbles: got span %0d cycles, want 13", last_fire - first_fire);
        end
    endtask

    task automatic test_packet_lock();
        bit armed = 1'b0;
        do_reset();
        lock_chk = 1'b1;
        add_packets(2, 1, 5);
        exp_pkt(2, 0, 5);
        for (int k = 0; k < 30 && exp_beats.size() > 0; k++) begin
            if (!armed && src_beat[2] == 2) begin
                armed = 1'b1;
                add_packets(0, 1, 1);
                exp_pkt(0, 0, 1);
            end
            step();
        end
        lock_chk = 1'b0;
        total++;
        if (exp_beats.size() != 0 || !armed) begin
            bad++;
            $display("FAIL lock_timeout: got %0d beats left armed=%0d, want 0 armed=1",
                     exp_beats.size(), armed);
        end
    endtask

    task automatic test_tag_full();
        do_reset();
        add_packets(1, 9, 1);
        for (int p = 0; p < 9; p++) exp_pkt(1, p, 1);
        repeat (30) step();
        #1;
        total++;
        if (exp_beats.size() != 1) begin
            bad++;
            $display("FAIL full_outstanding: got %0d beats left, want 1", exp_beats.size());
        end
        chk("full_add_s_tvalid", 64'(add_s_tvalid), 64'd0);
        chk("full_req1_tready", 64'(req_tready[1]), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        add_m_tvalid = 1'b1;
        add_m_tdata  = 32'h11;
        add_m_tlast  = 1'b1;
        rsp_tready   = 4'b0010;
        #1;
        chk("full_rsp_tvalid", 64'(rsp_tvalid), 64'b0010);
        chk("full_add_m_tready", 64'(add_m_tready), 64'd1);
        step();
        add_m_tvalid = 1'b0;
        rsp_tready   = '0;
        #1;
        chk("full_arb_cycle", 64'(add_s_tvalid), 64'd0);
        step();
        #1;
        chk("full_regrant_valid", 64'(add_s_tvalid), 64'd1);
        chk("full_regrant_id", 64'(grant_id), 64'd1);
        step();
        chk("full_drained", 64'(exp_beats.size()), 64'd0);
    endtask

    task automatic test_result_routing();
        do_reset();
        add_packets(3, 1, 1);
        exp_pkt(3, 0, 1);
        repeat (3) step();
        add_packets(1, 1, 1);
        exp_pkt(1, 0, 1);
        repeat (3) step();
        chk("route_sent", 64'(exp_beats.size()), 64'd0);
        add_m_tvalid = 1'b1;
        add_m_tdata  = 32'h0000_0005;
        add_m_tlast  = 1'b1;
        #1;
        chk("route_vld_req3", 64'(rsp_tvalid), 64'b1000);
        chk("route_data5", 64'(rsp_tdata), 64'h5);
        chk("route_stall3", 64'(add_m_tready), 64'd0);
        step();
        rsp_tready = 4'b0010;
        #1;
        chk("route_wrong_ready", 64'(add_m_tready), 64'd0);
        step();
        rsp_tready = 4'b1000;
        #1;
        chk("route_ready3", 64'(add_m_tready), 64'd1);
        step();
        add_m_tdata = 32'h0000_0009;
        rsp_tready  = '0;
        #1;
        chk("route_vld_req1", 64'(rsp_tvalid), 64'b0010);
        chk("route_data9", 64'(rsp_tdata), 64'h9);
        chk("route_stall1", 64'(add_m_tready), 64'd0);
        step();
        rsp_tready = 4'b0010;
        #1;
        chk("route_ready1", 64'(add_m_tready), 64'd1);
        step();
        add_m_tvalid = 1'b0;
        rsp_tready   = '0;
        #1;
        chk("route_tags_done", 64'(exp_tags.size()), 64'd0);
        chk("route_idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic test_tag_err();
        chk("err_before", 64'(tag_err), 64'd0);
        add_m_tvalid = 1'b1;
        #1;
        chk("err_m_tready", 64'(add_m_tready), 64'd0);
        chk("err_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        step();
        add_m_tvalid = 1'b0;
        #1;
        chk("err_set", 64'(tag_err), 64'd1);
        repeat (3) step();
        chk("err_sticky", 64'(tag_err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(tag_err), 64'd0);
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        add_packets(1, 1, 4);
        exp_pkt(1, 0, 4);
        for (int k = 0; k < 10 && src_beat[1] != 2; k++) step();
        chk("mid_beats_sent", 64'(src_beat[1]), 64'd2);
        #1;
        aresetn = 1'b0;
        #1;
        chk("mid_req_tready", 64'(req_tready), 64'd0);
        chk("mid_add_s_tvalid", 64'(add_s_tvalid), 64'd0);
        chk("mid_add_m_tready", 64'(add_m_tready), 64'd0);
        chk("mid_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        do_reset();
        #1;
        chk("mid_post_busy", 64'(busy), 64'd0);
        chk("mid_post_grant", 64'(grant_id), 64'd0);
        add_packets(1, 1, 1);
        exp_pkt(1, 0, 1);
        #1;
        chk("mid_new_arb", 64'(add_s_tvalid), 64'd0);
        step();
        #1;
        chk("mid_new_valid", 64'(add_s_tvalid), 64'd1);
        chk("mid_new_grant", 64'(grant_id), 64'd1);
        step();
        chk("mid_new_done", 64'(exp_beats.size()), 64'd0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_tag_full();
        test_result_routing();
        test_tag_err();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before 200000");
        $fatal(1);
    end

endmodule
